commit_monitor: RTL and testbench
=================================

// Module: commit_monitor
//
// PURPOSE
//   Synthesizable retire-stream monitor. It sits directly downstream of the OoO core's ROB commit
//   port and is instantiated by the top-level bench alongside the DUT.
//   - Counts retired instructions, pipeline flushes and run cycles.
//   - Detects the halt instruction and freezes all statistics when it retires.
//   - Flags a hung core when nothing retires for a programmable number of cycles.
//   - Provides the bench's flush/commit statistics and end-of-test condition.
//
// PARAMETERS
//   RETIRE_W    2              number of commit lanes per cycle; lane 0 is oldest
//   CNT_W       64             width of every statistics counter
//   TIMEOUT     100000         consecutive no-commit RUN cycles before hang is declared (>=2)
//   HALT_INSN   32'hF0002013   encoding that ends the test (slti x0,x0,-256)
//   IPC_WINDOW  1024           sample window length in cycles (used only with the macro below)
//
// PORTS
//   clk              in   1            core clock
//   rst_n            in   1            asynchronous reset, active-low
//   commit_valid_i   in   RETIRE_W     per-lane retire valid; valid lanes are contiguous from lane 0
//   commit_insn_i    in   RETIRE_W*32  per-lane retired instruction word; lane k = [32k+31:32k]
//   flush_i          in   1            core pipeline flush (mispredict/exception), 1-cycle pulse
//   state_o          out  2            2'd0 RUN, 2'd1 HALTED, 2'd2 HUNG
//   halted_o         out  1            state_o==HALTED
//   hung_o           out  1            state_o==HUNG
//   commit_count_o   out  CNT_W        instructions retired, including the halt instruction
//   flush_count_o    out  CNT_W        flushes seen while in RUN
//   cycle_count_o    out  CNT_W        RUN cycles elapsed since reset
//
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=RUN and all counters=0; halted_o=hung_o=0; internal idle counter=0.
//     Reset asserted mid-run clears everything immediately, regardless of clock.
//   - Outputs are registered: a cycle-N event is visible on the outputs at cycle N+1.
//   - RUN, every cycle:
//     - cycle_count += 1.
//     - Lane scan from lane 0 upward; n = number of valid lanes up to and including the first halt lane.
//     - Lanes after a halt lane are ignored even when valid.
//     - commit_count += n.
//     - flush_i=1 -> flush_count += 1. A flush and commits in the same cycle are both counted.
//   - Halt: any valid lane whose instruction equals HALT_INSN -> RUN->HALTED. That cycle's commits
//     and flush are still counted.
//   - Watchdog:
//     - Idle counter clears on any cycle with n>0; otherwise it increments.
//     - Idle count reaching TIMEOUT-1 with no commit that cycle -> RUN->HUNG.
//     - Halt takes priority over hang in the same cycle.
//   - HALTED and HUNG are sticky until reset. All counters freeze; flush_i and commits are ignored.
//   - Every counter saturates at all-ones and never wraps.
//   - A lane with commit_valid_i=0 is ignored entirely, including its instruction word.
//   - Illegal state encoding 2'd3 -> HUNG.
//
// CONFIGURATION
//   COMMIT_MONITOR_IPC_EN defined:
//     - Added ports: win_commits_o (out, CNT_W) and win_done_o (out, 1).
//     - A window counter runs only in RUN. Every IPC_WINDOW RUN cycles, win_done_o pulses for 1 cycle.
//     - With that pulse, win_commits_o holds the commits retired in the completed window.
//     - Both outputs reset to 0; win_commits_o holds its value between pulses.
//     - Any partial window at halt or hang is discarded.
//   COMMIT_MONITOR_IPC_EN undefined:
//     - The added ports and logic are absent.
//     - All other behaviour is identical.
//
// TESTING
//   1. Reset release, then 10 cycles with both lanes valid and non-halt words
//      -> commit_count=20, cycle_count=10, state RUN.
//   2. Lane0 = ADDI and lane1 = HALT_INSN in one cycle
//      -> commit_count += 2, halted_o=1 next cycle.
//      Then 5 more cycles of commits and flushes -> all counters unchanged.
//   3. Lane0 = HALT_INSN and lane1 valid -> commit_count += 1 only; lane1 ignored.
//   4. TIMEOUT=16, no commits after reset -> hung_o=1 visible on the 17th cycle.
//      Inject one commit at idle count 15 instead -> stays RUN.
//   5. flush_i pulsed on 3 cycles, one of them alongside 2 commits -> flush_count=3, commits counted.
//      Assert rst_n mid-run -> all outputs 0 with no clock edge.
//   6. COMMIT_MONITOR_IPC_EN, IPC_WINDOW=8, one commit every cycle
//      -> win_done_o pulses every 8 cycles with win_commits_o=8.

Source files
------------

// File: rtl/commit_monitor.sv
// rtl/commit_monitor.sv - ROB retire-stream monitor: commit/flush/cycle stats, halt detect, hang watchdog.
// Optional per-window commit sampling is enabled by defining COMMIT_MONITOR_IPC_EN.
module commit_monitor #(
    parameter int unsigned RETIRE_W   = 2,
    parameter int unsigned CNT_W      = 64,
    parameter int unsigned TIMEOUT    = 100000,
    parameter logic [31:0] HALT_INSN  = 32'hF0002013,
    parameter int unsigned IPC_WINDOW = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [RETIRE_W-1:0]    commit_valid_i,
    input  logic [RETIRE_W*32-1:0] commit_insn_i,
    input  logic                   flush_i,
    output logic [1:0]             state_o,
    output logic                   halted_o,
    output logic                   hung_o,
    output logic [CNT_W-1:0]       commit_count_o,
    output logic [CNT_W-1:0]       flush_count_o,
    output logic [CNT_W-1:0]       cycle_count_o
`ifdef COMMIT_MONITOR_IPC_EN
    ,
    output logic [CNT_W-1:0]       win_commits_o,
    output logic                   win_done_o
`endif
);

    localparam int unsigned LANE_W = $clog2(RETIRE_W + 1);
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_HUNG   = 2'd2
    } state_t;

    state_t              state_q;
    logic [IDLE_W-1:0]   idle_q;
    logic [LANE_W-1:0]   n;
    logic                halt_seen;
    logic [CNT_W:0]      commit_sum;

    // Lanes younger than a retiring halt never count, even if the core marks them valid.
    always_comb begin
        n         = '0;
        halt_seen = 1'b0;
        for (int k = 0; k < RETIRE_W; k++) begin
            if (!halt_seen && commit_valid_i[k]) begin
                n = n + LANE_W'(1);
                if (commit_insn_i[32*k +: 32] == HALT_INSN)
                    halt_seen = 1'b1;
            end
        end
    end

    assign commit_sum = {1'b0, commit_count_o} + (CNT_W + 1)'(n);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_RUN;
            idle_q         <= '0;
            commit_count_o <= '0;
            flush_count_o  <= '0;
            cycle_count_o  <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (~&cycle_count_o)
                        cycle_count_o <= cycle_count_o + CNT_W'(1);
                    if (flush_i && ~&flush_count_o)
                        flush_count_o <= flush_count_o + CNT_W'(1);
                    commit_count_o <= commit_sum[CNT_W] ? '1 : commit_sum[CNT_W-1:0];
                    if (n != '0)
                        idle_q <= '0;
                    else
                        idle_q <= idle_q + IDLE_W'(1);
                    if (halt_seen)
                        state_q <= ST_HALTED;
                    else if (n == '0 && idle_q == IDLE_W'(TIMEOUT - 1))
                        state_q <= ST_HUNG;
                end
                ST_HALTED, ST_HUNG: begin
                end
                default: state_q <= ST_HUNG;
            endcase
        end
    end

    assign state_o  = state_q;
    assign halted_o = (state_q == ST_HALTED);
    assign hung_o   = (state_q == ST_HUNG);

`ifdef COMMIT_MONITOR_IPC_EN
    localparam int unsigned WIN_W = $clog2(IPC_WINDOW + 1);

    logic [WIN_W-1:0] win_cnt_q;
    logic [CNT_W-1:0] win_acc_q;

    // The window only advances in RUN, so a partial window is simply dropped at halt/hang.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_q     <= '0;
            win_acc_q     <= '0;
            win_commits_o <= '0;
            win_done_o    <= 1'b0;
        end else if (state_q == ST_RUN) begin
            if (win_cnt_q == WIN_W'(IPC_WINDOW - 1)) begin
                win_cnt_q     <= '0;
                win_acc_q     <= '0;
                win_commits_o <= win_acc_q + CNT_W'(n);
                win_done_o    <= 1'b1;
            end else begin
                win_cnt_q  <= win_cnt_q + WIN_W'(1);
                win_acc_q  <= win_acc_q + CNT_W'(n);
                win_done_o <= 1'b0;
            end
        end else begin
            win_done_o <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_commit_monitor.sv
// tb/tb_commit_monitor.sv - directed-vector bench for commit_monitor (CNT_W=6, TIMEOUT=16, IPC_WINDOW=8).
// Exercises the window outputs when COMMIT_MONITOR_IPC_EN is defined.
module tb_commit_monitor;

    localparam logic [31:0] HALT = 32'hF0002013;
    localparam logic [31:0] ADDI = 32'h00100093;

    logic        clk;
    logic        rst_n;
    logic [1:0]  valid;
    logic [63:0] insn;
    logic        flush;
    logic [1:0]  state;
    logic        halted;
    logic        hung;
    logic [5:0]  commit_count;
    logic [5:0]  flush_count;
    logic [5:0]  cycle_count;
`ifdef COMMIT_MONITOR_IPC_EN
    logic [5:0]  win_commits;
    logic        win_done;
`endif

    int total = 0;
    int bad   = 0;

    commit_monitor #(
        .RETIRE_W   (2),
        .CNT_W      (6),
        .TIMEOUT    (16),
        .HALT_INSN  (HALT),
        .IPC_WINDOW (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .commit_valid_i (valid),
        .commit_insn_i  (insn),
        .flush_i        (flush),
        .state_o        (state),
        .halted_o       (halted),
        .hung_o         (hung),
        .commit_count_o (commit_count),
        .flush_count_o  (flush_count),
        .cycle_count_o  (cycle_count)
`ifdef COMMIT_MONITOR_IPC_EN
        ,
        .win_commits_o  (win_commits),
        .win_done_o     (win_done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1, input logic f);
        valid = v;
        insn  = {i1, i0};
        flush = f;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        valid = '0;
        insn  = '0;
        flush = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state and steady dual-lane retire, then saturation.
        do_reset();
        check("rst_state", state, 2'd0);
        check("rst_halted", halted, 1'b0);
        check("rst_hung", hung, 1'b0);
        check("rst_commit", commit_count, 6'd0);
        check("rst_cycle", cycle_count, 6'd0);
        repeat (10) cyc(2'b11, ADDI, ADDI, 1'b0);
        check("t1_commit", commit_count, 6'd20);
        check("t1_cycle", cycle_count, 6'd10);
        check("t1_state", state, 2'd0);
        repeat (22) cyc(2'b11, ADDI, ADDI, 1'b0);
        check("sat_commit", commit_count, 6'd63);
        check("sat_cycle_mid", cycle_count, 6'd32);
        repeat (32) cyc(2'b11, ADDI, ADDI, 1'b0);
        check("sat_commit_hold", commit_count, 6'd63);
        check("sat_cycle", cycle_count, 6'd63);

        // Halt in lane 1 counts both lanes, then everything freezes.
        do_reset();
        cyc(2'b11, ADDI, ADDI, 1'b0);
        cyc(2'b11, ADDI, HALT, 1'b0);
        check("t2_commit", commit_count, 6'd4);
        check("t2_halted", halted, 1'b1);
        check("t2_state", state, 2'd1);
        check("t2_cycle", cycle_count, 6'd2);
        repeat (5) cyc(2'b11, ADDI, ADDI, 1'b1);
        check("t2_commit_frozen", commit_count, 6'd4);
        check("t2_flush_frozen", flush_count, 6'd0);
        check("t2_cycle_frozen", cycle_count, 6'd2);
        check("t2_state_sticky", state, 2'd1);

        // Halt word on an invalid lane is ignored; halt in lane 0 masks lane 1.
        do_reset();
        cyc(2'b01, ADDI, HALT, 1'b0);
        check("t3_invalid_halt", state, 2'd0);
        check("t3_commit1", commit_count, 6'd1);
        cyc(2'b11, HALT, ADDI, 1'b0);
        check("t3_commit2", commit_count, 6'd2);
        check("t3_halted", halted, 1'b1);

        // Watchdog fires after TIMEOUT idle cycles.
        do_reset();
        repeat (15) cyc(2'b00, ADDI, ADDI, 1'b0);
        check("t4_not_yet", state, 2'd0);
        cyc(2'b00, ADDI, ADDI, 1'b0);
        check("t4_hung", hung, 1'b1);
        check("t4_state", state, 2'd2);
        check("t4_cycle", cycle_count, 6'd16);
        repeat (3) cyc(2'b11, ADDI, ADDI, 1'b1);
        check("t4_commit_frozen", commit_count, 6'd0);
        check("t4_cycle_frozen", cycle_count, 6'd16);

        // A commit at idle count 15 rearms the watchdog.
        do_reset();
        repeat (15) cyc(2'b00, ADDI, ADDI, 1'b0);
        cyc(2'b01, ADDI, ADDI, 1'b0);
        check("t4b_run", state, 2'd0);
        check("t4b_commit", commit_count, 6'd1);
        repeat (15) cyc(2'b00, ADDI, ADDI, 1'b0);
        check("t4b_still_run", state, 2'd0);
        cyc(2'b00, ADDI, ADDI, 1'b0);
        check("t4b_hung", hung, 1'b1);

        // Flush counting, then asynchronous reset mid-run.
        do_reset();
        cyc(2'b00, ADDI, ADDI, 1'b1);
        cyc(2'b11, ADDI, ADDI, 1'b1);
        cyc(2'b00, ADDI, ADDI, 1'b0);
        cyc(2'b00, ADDI, ADDI, 1'b1);
        check("t5_flush", flush_count, 6'd3);
        check("t5_commit", commit_count, 6'd2);
        check("t5_cycle", cycle_count, 6'd4);
        rst_n = 1'b0;
        #1;
        check("t5_arst_commit", commit_count, 6'd0);
        check("t5_arst_flush", flush_count, 6'd0);
        check("t5_arst_cycle", cycle_count, 6'd0);
        check("t5_arst_state", state, 2'd0);

`ifdef COMMIT_MONITOR_IPC_EN
        // One commit per cycle gives 8 per window; then two per cycle gives 16.
        do_reset();
        check("w_rst_done", win_done, 1'b0);
        check("w_rst_commits", win_commits, 6'd0);
        repeat (7) cyc(2'b01, ADDI, ADDI, 1'b0);
        check("w_pre_done", win_done, 1'b0);
        cyc(2'b01, ADDI, ADDI, 1'b0);
        check("w1_done", win_done, 1'b1);
        check("w1_commits", win_commits, 6'd8);
        cyc(2'b11, ADDI, ADDI, 1'b0);
        check("w1_pulse_end", win_done, 1'b0);
        check("w1_hold", win_commits, 6'd8);
        repeat (7) cyc(2'b11, ADDI, ADDI, 1'b0);
        check("w2_done", win_done, 1'b1);
        check("w2_commits", win_commits, 6'd16);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1);
    end

endmodule
